// File: rtl/cp0_pkg.sv
// cp0_pkg: shared CP0 register numbers and status/cause field positions for the interrupt controller.
package cp0_pkg;
  typedef enum logic [4:0] {
    SEL_STATUS = 5'd12,
    SEL_CAUSE  = 5'd13,
    SEL_EPC    = 5'd14
  } cp0_sel_e;
  localparam int ST_IEC = 0;
  localparam int ST_IEP = 2;
  localparam int ST_IEO = 4;
  localparam int ST_IM  = 8;
  localparam int CA_ID  = 2;
  localparam int CA_IP  = 8;
  localparam int ID_W   = 3;
  localparam int EXCCODE_INT = 0;
endpackage

// File: rtl/intc_prio_enc.sv
// intc_prio_enc: lowest-index-wins priority encoder over the masked interrupt request vector.
module intc_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  output logic         valid_o,
  output logic [2:0]   id_o
);
  assign valid_o = |req_i;
  always_comb begin
    id_o = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req_i[k]) id_o = 3'(k);
  end
endmodule

// File: rtl/cp0_intctl.sv
// cp0_intctl: CP0 interrupt controller with edge/level sources, mask, fixed priority,
// optional vectored entry and a three-level interrupt-enable stack.
module cp0_intctl
  import cp0_pkg::*;
#(
  parameter int          NUM_IRQ   = 4,
  parameter logic [7:0]  EDGE_MASK = 8'h0F,
  parameter logic [31:0] EXC_BASE  = 32'h0000_0180,
  parameter int          VECTORED  = 0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [31:0]        pc_i,
  input  logic               rfe_i,
  input  logic               mtc0_i,
  input  logic               mfc0_i,
  input  logic [4:0]         cp0_sel_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o,
  output logic               take_exc_o,
  output logic [31:0]        exc_pc_o,
  output logic [31:0]        epc_o,
  output logic               ie_o
);
  localparam logic [NUM_IRQ-1:0] EDGE = EDGE_MASK[NUM_IRQ-1:0];
  logic               iec_q, iep_q, ieo_q, iec_d, iep_d, ieo_d;
  logic [NUM_IRQ-1:0] im_q, im_d, ip_q, ip_d, prev_q;
  logic [ID_W-1:0]    id_q, id_d, id;
  logic [31:0]        epc_q, epc_d, status, cause;
  logic [NUM_IRQ-1:0] ip_eff, req, w1c;
  logic               valid, take, wr, wr_st, wr_ca, wr_epc;
  logic               unused_ok;
  assign unused_ok = ^{mfc0_i, wdata_i};
  // Level sources bypass the register so a held line requests with zero latency.
  assign ip_eff = (ip_q & EDGE) | (irq_i & ~EDGE);
  assign req    = ip_eff & im_q;
  intc_prio_enc #(.N(NUM_IRQ)) u_enc (
    .req_i  (req),
    .valid_o(valid),
    .id_o   (id)
  );
  assign take   = valid & iec_q & ~rfe_i;
  // rfe and mtc0 never share a cycle from the decoder; rfe wins if they do.
  assign wr     = mtc0_i & ~take & ~rfe_i;
  assign wr_st  = wr & (cp0_sel_i == SEL_STATUS);
  assign wr_ca  = wr & (cp0_sel_i == SEL_CAUSE);
  assign wr_epc = wr & (cp0_sel_i == SEL_EPC);
  assign w1c    = wr_ca ? wdata_i[CA_IP +: NUM_IRQ] : '0;
  always_comb begin
    ip_d  = (EDGE & ((irq_i & ~prev_q) | (ip_q & ~w1c))) | (~EDGE & irq_i);
    iec_d = take ? 1'b0  : rfe_i ? iep_q : wr_st ? wdata_i[ST_IEC] : iec_q;
    iep_d = take ? iec_q : rfe_i ? ieo_q : wr_st ? wdata_i[ST_IEP] : iep_q;
    ieo_d = take ? iep_q : wr_st ? wdata_i[ST_IEO] : ieo_q;
    im_d  = wr_st ? wdata_i[ST_IM +: NUM_IRQ] : im_q;
    epc_d = take ? pc_i : wr_epc ? wdata_i : epc_q;
    id_d  = take ? id : id_q;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      iec_q  <= 1'b0;
      iep_q  <= 1'b0;
      ieo_q  <= 1'b0;
      im_q   <= '0;
      ip_q   <= '0;
      prev_q <= '0;
      id_q   <= ID_W'(EXCCODE_INT);
      epc_q  <= '0;
    end else begin
      iec_q  <= iec_d;
      iep_q  <= iep_d;
      ieo_q  <= ieo_d;
      im_q   <= im_d;
      ip_q   <= ip_d;
      prev_q <= irq_i;
      id_q   <= id_d;
      epc_q  <= epc_d;
    end
  end
  always_comb begin
    status                   = '0;
    status[ST_IEC]           = iec_q;
    status[ST_IEP]           = iep_q;
    status[ST_IEO]           = ieo_q;
    status[ST_IM +: NUM_IRQ] = im_q;
    cause                    = '0;
    cause[CA_ID +: ID_W]     = id_q;
    cause[CA_IP +: NUM_IRQ]  = ip_q;
    rdata_o = cp0_sel_i == SEL_STATUS ? status :
              cp0_sel_i == SEL_CAUSE  ? cause  :
              cp0_sel_i == SEL_EPC    ? epc_q  : '0;
  end
  assign take_exc_o = take;
  assign exc_pc_o   = VECTORED != 0 ? EXC_BASE + {26'd0, id, 3'b000} : EXC_BASE;
  assign epc_o      = epc_q;
  assign ie_o       = iec_q;
endmodule

// File: tb/tb_cp0_intctl.sv
// tb_cp0_intctl: scoreboard bench; expectations are queued as each cycle is driven and compared on the falling edge.
module tb_cp0_intctl;
  localparam int O_TAKE = 0, O_XPC = 1, O_RD = 2, O_EPC = 3, O_IE = 4;
  typedef struct {
    string       tag;
    int          o;
    logic [31:0] v;
  } exp_t;
  logic        clk, reset, rfe, mtc0, mfc0, take_exc, ie;
  logic [3:0]  irq;
  logic [4:0]  cp0_sel;
  logic [31:0] pc, wdata, rdata, exc_pc, epc;
  exp_t        sb[$];
  exp_t        e;
  int          checks = 0, fails = 0;
  cp0_intctl #(
    .NUM_IRQ  (4),
    .EDGE_MASK(8'h0E),
    .EXC_BASE (32'h0000_0180),
    .VECTORED (1)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .irq_i     (irq),
    .pc_i      (pc),
    .rfe_i     (rfe),
    .mtc0_i    (mtc0),
    .mfc0_i    (mfc0),
    .cp0_sel_i (cp0_sel),
    .wdata_i   (wdata),
    .rdata_o   (rdata),
    .take_exc_o(take_exc),
    .exc_pc_o  (exc_pc),
    .epc_o     (epc),
    .ie_o      (ie)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] obs(input int o);
    case (o)
      O_TAKE:  obs = {31'd0, take_exc};
      O_XPC:   obs = exc_pc;
      O_RD:    obs = rdata;
      O_EPC:   obs = epc;
      default: obs = {31'd0, ie};
    endcase
  endfunction
  always @(negedge clk)
    while (sb.size() != 0) begin
      e = sb.pop_front();
      chk(e.tag, obs(e.o), e.v);
    end
  task automatic drv(input logic [3:0] i, input logic [31:0] p, input logic r, input logic m,
                     input logic [4:0] s, input logic [31:0] w);
    irq = i; pc = p; rfe = r; mtc0 = m; mfc0 = ~m; cp0_sel = s; wdata = w;
  endtask
  task automatic ex(input string tag, input int o, input logic [31:0] v);
    exp_t x;
    x.tag = tag; x.o = o; x.v = v;
    sb.push_back(x);
  endtask
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b1;
    drv(4'h0, 32'h0, 1'b0, 1'b0, 5'd12, 32'h0);
    @(posedge clk); #1;
    ex("rst_take", O_TAKE, 0); ex("rst_xpc", O_XPC, 32'h180); ex("rst_ie", O_IE, 0); ex("rst_status", O_RD, 0);
    tick();
    reset = 1'b0;
    drv(4'h0, 32'h0, 0, 1, 5'd12, 32'h0F01);   ex("t1_wr_take", O_TAKE, 0); tick();
    drv(4'h4, 32'h3C, 0, 0, 5'd12, 32'h0);     ex("t1_status", O_RD, 32'hF01); ex("t1_pulse_take", O_TAKE, 0); tick();
    drv(4'h0, 32'h40, 0, 0, 5'd13, 32'h0);     ex("t1_take", O_TAKE, 1); ex("t1_xpc", O_XPC, 32'h190); ex("t1_ip2", O_RD, 32'h400); tick();
    drv(4'h0, 32'h44, 0, 0, 5'd12, 32'h0);     ex("t1_push", O_RD, 32'hF04); ex("t1_epc", O_EPC, 32'h40); ex("t1_ie", O_IE, 0); ex("t1_no_take", O_TAKE, 0); tick();
    drv(4'h0, 32'h48, 0, 0, 5'd13, 32'h0);     ex("t1_cause", O_RD, 32'h408); tick();
    drv(4'h0, 32'h4C, 0, 1, 5'd13, 32'h400);   tick();
    drv(4'h0, 32'h50, 0, 0, 5'd13, 32'h0);     ex("t1_w1c", O_RD, 32'h008); tick();
    drv(4'h0, 32'h54, 1, 0, 5'd12, 32'h0);     ex("t1_rfe_take", O_TAKE, 0); tick();
    drv(4'h0, 32'h40, 0, 0, 5'd12, 32'h0);     ex("t1_pop", O_RD, 32'hF01); ex("t1_pop_ie", O_IE, 1); tick();
    drv(4'hA, 32'h100, 0, 0, 5'd12, 32'h0);    ex("t2_rise_take", O_TAKE, 0); tick();
    drv(4'h0, 32'h104, 0, 0, 5'd13, 32'h0);    ex("t2_take", O_TAKE, 1); ex("t2_xpc1", O_XPC, 32'h188); ex("t2_ip13", O_RD, 32'hA08); tick();
    drv(4'h0, 32'h180, 0, 1, 5'd13, 32'h200);  ex("t2_epc", O_EPC, 32'h104); tick();
    drv(4'h0, 32'h184, 1, 0, 5'd13, 32'h0);    ex("t2_cause", O_RD, 32'h804); ex("t2_rfe_take", O_TAKE, 0); tick();
    drv(4'h0, 32'h200, 0, 0, 5'd12, 32'h0);    ex("t2_take3", O_TAKE, 1); ex("t2_xpc3", O_XPC, 32'h198); ex("t2_status", O_RD, 32'hF01); tick();
    drv(4'h0, 32'h198, 0, 0, 5'd13, 32'h0);    ex("t2_cause3", O_RD, 32'h80C); ex("t2_epc3", O_EPC, 32'h200); tick();
    drv(4'h0, 32'h19C, 0, 1, 5'd13, 32'h800);  tick();
    drv(4'h0, 32'h1A0, 1, 0, 5'd13, 32'h0);    tick();
    drv(4'h0, 32'h204, 0, 0, 5'd13, 32'h0);    ex("t2_clear", O_RD, 32'h00C); ex("t2_idle", O_TAKE, 0); tick();
    drv(4'h1, 32'h300, 0, 0, 5'd13, 32'h0);    ex("t3_level_take", O_TAKE, 1); ex("t3_xpc0", O_XPC, 32'h180); ex("t3_ipreg", O_RD, 32'h00C); tick();
    drv(4'h1, 32'h180, 0, 1, 5'd13, 32'h100);  ex("t3_masked", O_TAKE, 0); tick();
    drv(4'h1, 32'h184, 0, 0, 5'd13, 32'h0);    ex("t3_ip0_held", O_RD, 32'h100); tick();
    drv(4'h1, 32'h188, 1, 0, 5'd12, 32'h0);    ex("t3_rfe_take", O_TAKE, 0); tick();
    drv(4'h1, 32'h304, 0, 0, 5'd12, 32'h0);    ex("t3_retake", O_TAKE, 1); ex("t3_pop", O_RD, 32'hF01); tick();
    drv(4'h1, 32'h180, 0, 0, 5'd12, 32'h0);    ex("t3_push", O_RD, 32'hF04); ex("t3_epc", O_EPC, 32'h304); tick();
    drv(4'h1, 32'h184, 0, 1, 5'd12, 32'h0F05); ex("t4_wr_take", O_TAKE, 0); tick();
    drv(4'h1, 32'h188, 1, 0, 5'd12, 32'h0);    ex("t4_rfe_block", O_TAKE, 0); ex("t4_status", O_RD, 32'hF05); tick();
    drv(4'h1, 32'h308, 0, 1, 5'd12, 32'h0005); ex("t4_take", O_TAKE, 1); ex("t4_pop", O_RD, 32'hF01); tick();
    drv(4'h0, 32'h180, 0, 0, 5'd12, 32'h0);    ex("t4_mtc0_drop", O_RD, 32'hF04); ex("t4_epc", O_EPC, 32'h308); tick();
    drv(4'h0, 32'h184, 0, 1, 5'd12, 32'h0D01); ex("t5_wr_take", O_TAKE, 0); tick();
    drv(4'h2, 32'h3F0, 0, 0, 5'd12, 32'h0);    ex("t5_pulse_take", O_TAKE, 0); tick();
    drv(4'h0, 32'h3F4, 0, 0, 5'd13, 32'h0);    ex("t5_im0_take", O_TAKE, 0); ex("t5_ip1", O_RD, 32'h200); tick();
    drv(4'h0, 32'h3F8, 0, 1, 5'd12, 32'h0F01); ex("t5_wr_im", O_TAKE, 0); tick();
    drv(4'h0, 32'h400, 0, 0, 5'd13, 32'h0);    ex("t5_take", O_TAKE, 1); ex("t5_xpc", O_XPC, 32'h188); tick();
    drv(4'h0, 32'h188, 0, 0, 5'd14, 32'h0);    ex("t5_epc_rd", O_RD, 32'h400); ex("t5_ie", O_IE, 0); tick();
    drv(4'h0, 32'h18C, 0, 0, 5'd15, 32'h0);    ex("sel15", O_RD, 0); tick();
    drv(4'h0, 32'h190, 0, 1, 5'd9, 32'hFFFF);  ex("sel9_wr", O_RD, 0); tick();
    drv(4'h0, 32'h194, 0, 0, 5'd12, 32'h0);    ex("sel9_ignored", O_RD, 32'hF04); tick();
    reset = 1'b1;
    drv(4'h0, 32'h198, 0, 0, 5'd12, 32'h0);    ex("t6_status", O_RD, 0); ex("t6_take", O_TAKE, 0); ex("t6_epc", O_EPC, 0); ex("t6_xpc", O_XPC, 32'h180); tick();
    drv(4'h0, 32'h198, 0, 0, 5'd13, 32'h0);    ex("t6_cause", O_RD, 0); tick();
    drv(4'h0, 32'h198, 0, 0, 5'd14, 32'h0);    ex("t6_epc_rd", O_RD, 0); tick();
    reset = 1'b0;
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
